// File: rtl/pipe_issue_if.sv
// rtl/pipe_issue_if.sv - producer/pipeline signal bundle for the pipe_issue instruction issue unit

interface pipe_issue_if #(
    parameter int DEPTH = 4
);
    // producer side
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               in_rs1;
    logic [3:0]               in_rs2;
    logic [3:0]               in_rd;
    logic [3:0]               in_func;
    logic [7:0]               in_addr;
    logic                     run;

    // pipeline side
    logic [3:0]               rs1;
    logic [3:0]               rs2;
    logic [3:0]               rd;
    logic [3:0]               func;
    logic [7:0]               addr;
    logic                     issue;
    logic [$clog2(DEPTH):0]   count;
    logic [15:0]              stall_cnt;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, run,
        input  in_ready, rs1, rs2, rd, func, addr, issue, count, stall_cnt
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr, run,
        output in_ready, rs1, rs2, rd, func, addr, issue, count, stall_cnt
    );
endinterface

// File: rtl/pipe_issue.sv
// rtl/pipe_issue.sv - instruction FIFO with RAW-hazard bubble insertion; stall counter enabled by PIPE_ISSUE_STALLCNT_EN

module pipe_issue #(
    parameter int         DEPTH      = 4,
    parameter int         HAZ_STAGES = 2,
    parameter logic [7:0] BUB_ADDR   = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_issue_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam int         CW       = AW + 1;
    localparam logic [3:0] BUB_FUNC = 4'd3;

    logic [3:0]            mem_rs1  [DEPTH];
    logic [3:0]            mem_rs2  [DEPTH];
    logic [3:0]            mem_rd   [DEPTH];
    logic [3:0]            mem_func [DEPTH];
    logic [7:0]            mem_addr [DEPTH];

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;

    logic [HAZ_STAGES-1:0] sb_valid;
    logic [3:0]            sb_rd [HAZ_STAGES];

    logic [3:0]            out_rs1;
    logic [3:0]            out_rs2;
    logic [3:0]            out_rd;
    logic [3:0]            out_func;
    logic [7:0]            out_addr;
    logic                  out_issue;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  hazard;
    logic [3:0]            head_rs1;
    logic [3:0]            head_rs2;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = bus.in_valid && !full;
    assign head_rs1 = mem_rs1[rd_ptr];
    assign head_rs2 = mem_rs2[rd_ptr];
    assign pop      = bus.run && !empty && !hazard;

    // Head sources against every destination still in flight ahead of the register bank
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_STAGES; i++) begin
            if (sb_valid[i] && ((sb_rd[i] == head_rs1) || (sb_rd[i] == head_rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    // FIFO storage write; contents are don't-care while outside the occupied window
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rs1[wr_ptr]  <= bus.in_rs1;
            mem_rs2[wr_ptr]  <= bus.in_rs2;
            mem_rd[wr_ptr]   <= bus.in_rd;
            mem_func[wr_ptr] <= bus.in_func;
            mem_addr[wr_ptr] <= bus.in_addr;
        end
    end

    // Pointers and occupancy; a pop never frees a slot for a push in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Scoreboard shifts every clock; bubbles enter as invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            for (int i = 0; i < HAZ_STAGES; i++) begin
                sb_rd[i] <= '0;
            end
        end else begin
            for (int i = HAZ_STAGES - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            sb_valid[0] <= pop;
            sb_rd[0]    <= pop ? mem_rd[rd_ptr] : 4'd0;
        end
    end

    // Pipeline field registers: popped head or the harmless r0 pass-A bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rs1   <= 4'd0;
            out_rs2   <= 4'd0;
            out_rd    <= 4'd0;
            out_func  <= BUB_FUNC;
            out_addr  <= BUB_ADDR;
            out_issue <= 1'b0;
        end else if (pop) begin
            out_rs1   <= mem_rs1[rd_ptr];
            out_rs2   <= mem_rs2[rd_ptr];
            out_rd    <= mem_rd[rd_ptr];
            out_func  <= mem_func[rd_ptr];
            out_addr  <= mem_addr[rd_ptr];
            out_issue <= 1'b1;
        end else begin
            out_rs1   <= 4'd0;
            out_rs2   <= 4'd0;
            out_rd    <= 4'd0;
            out_func  <= BUB_FUNC;
            out_addr  <= BUB_ADDR;
            out_issue <= 1'b0;
        end
    end

`ifdef PIPE_ISSUE_STALLCNT_EN
    logic [15:0] stall_q;

    // Count edges where issue was permitted and a head was waiting but blocked by a hazard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'd0;
        end else if (bus.run && !empty && hazard && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = 16'd0;
`endif

    assign bus.in_ready = !full;
    assign bus.count    = count_q;
    assign bus.rs1      = out_rs1;
    assign bus.rs2      = out_rs2;
    assign bus.rd       = out_rd;
    assign bus.func     = out_func;
    assign bus.addr     = out_addr;
    assign bus.issue    = out_issue;

endmodule

// File: tb/tb_pipe_issue.sv
// tb/tb_pipe_issue.sv - randomized and directed self-checking bench for pipe_issue against a timing-rule reference model

module tb_pipe_issue;
    localparam int DEPTH = 4;
    localparam int HAZ   = 2;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    localparam ins_t BUB = '{rs1: 4'd0, rs2: 4'd0, rd: 4'd0, func: 4'd3, addr: 8'd255};

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pipe_issue_if #(.DEPTH(DEPTH)) bus ();

    pipe_issue #(
        .DEPTH      (DEPTH),
        .HAZ_STAGES (HAZ),
        .BUB_ADDR   (8'd255)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents, edge index of the last issue writing each register, stall total
    ins_t mq[$];
    int   last_wr [16];
    int   m_edge;
    int   m_stall;
    ins_t e_out;
    logic e_issue;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_stall();
`ifdef PIPE_ISSUE_STALLCNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 16; r++) last_wr[r] = -1000;
        m_edge  = 0;
        m_stall = 0;
        e_out   = BUB;
        e_issue = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".issue"}, 32'(bus.issue), 32'(e_issue));
        chk({tag, ".rs1"},   32'(bus.rs1),   32'(e_out.rs1));
        chk({tag, ".rs2"},   32'(bus.rs2),   32'(e_out.rs2));
        chk({tag, ".rd"},    32'(bus.rd),    32'(e_out.rd));
        chk({tag, ".func"},  32'(bus.func),  32'(e_out.func));
        chk({tag, ".addr"},  32'(bus.addr),  32'(e_out.addr));
        chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'(exp_stall()));
    endtask

    // One clock: drive at negedge, predict from the rules, compare 1 time unit after the edge
    task automatic step(input string tag, input logic v, input ins_t ins, input logic r, output logic acc);
        logic rdy;
        logic hz;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_rs1   = ins.rs1;
        bus.in_rs2   = ins.rs2;
        bus.in_rd    = ins.rd;
        bus.in_func  = ins.func;
        bus.in_addr  = ins.addr;
        bus.run      = r;
        #1;
        rdy = (mq.size() < DEPTH);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        hz = 1'b0;
        if (mq.size() > 0) begin
            // a register issued at edge e is readable from edge e+HAZ+1 onward
            hz = ((m_edge - last_wr[mq[0].rs1]) <= HAZ) || ((m_edge - last_wr[mq[0].rs2]) <= HAZ);
        end
        if (r && (mq.size() > 0) && hz && (m_stall < 65535)) m_stall++;
        if (r && (mq.size() > 0) && !hz) begin
            e_out = mq.pop_front();
            e_issue = 1'b1;
            last_wr[e_out.rd] = m_edge;
        end else begin
            e_out = BUB;
            e_issue = 1'b0;
        end
        acc = v && rdy;
        if (acc) mq.push_back(ins);
        m_edge++;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input logic r, input int n);
        logic a;
        for (int k = 0; k < n; k++) step(tag, 1'b0, BUB, r, a);
    endtask

    function automatic ins_t mk(input int a, input int b, input int d, input int f, input int ad);
        ins_t t;
        t.rs1 = 4'(a); t.rs2 = 4'(b); t.rd = 4'(d); t.func = 4'(f); t.addr = 8'(ad);
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        ins_t fill [5];
        int   guard;
        int   gap;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_func = '0; bus.in_addr = '0;
        bus.run = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent back-to-back pair
        step("indep0", 1'b1, mk(3, 5, 10, 0, 125), 1'b1, a);
        step("indep1", 1'b1, mk(3, 8, 12, 2, 126), 1'b1, a);
        chk("indep.first_issue", 32'(bus.issue), 32'd1);
        step("indep2", 1'b0, BUB, 1'b1, a);
        chk("indep.second_issue", 32'(bus.addr), 32'd126);
        idle("indep_tail", 1'b1, 3);
        chk("indep.stall", 32'(bus.stall_cnt), 32'd0);

        // RAW: consumer of r10 waits two bubbles behind its producer
        m_stall = 0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        model_reset();
        step("raw0", 1'b1, mk(3, 5, 10, 0, 125), 1'b1, a);
        step("raw1", 1'b1, mk(10, 5, 14, 1, 128), 1'b1, a);
        chk("raw.producer", 32'(bus.addr), 32'd125);
        gap = 0;
        guard = 0;
        do begin
            step("raw_wait", 1'b0, BUB, 1'b1, a);
            gap++;
            guard++;
        end while (!bus.issue && guard < 10);
        chk("raw.gap_edges", 32'(gap), 32'd3);
        chk("raw.consumer", 32'(bus.addr), 32'd128);
`ifdef PIPE_ISSUE_STALLCNT_EN
        chk("raw.stall_cnt", 32'(bus.stall_cnt), 32'd2);
`else
        chk("raw.stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
        idle("raw_tail", 1'b1, 3);

        // Fill to DEPTH with run=0, fifth held, then drain in order
        for (int i = 0; i < 5; i++) fill[i] = mk(i + 1, i + 1, 0, 4, 10 + i);
        for (int i = 0; i < 4; i++) step("fill", 1'b1, fill[i], 1'b0, a);
        chk("full.count", 32'(bus.count), 32'd4);
        chk("full.in_ready", 32'(bus.in_ready), 32'd0);
        step("full_hold", 1'b1, fill[4], 1'b0, a);
        chk("full.fifth_rejected", 32'(a), 32'd0);
        guard = 0;
        do begin
            step("drain_push", 1'b1, fill[4], 1'b1, a);
            guard++;
        end while (!a && guard < 10);
        chk("full.fifth_accepted", 32'(a), 32'd1);
        idle("drain", 1'b1, 8);
        chk("full.empty", 32'(bus.count), 32'd0);

        // Concurrent push/pop at count=2
        step("cc0", 1'b1, mk(1, 1, 5, 0, 40), 1'b0, a);
        step("cc1", 1'b1, mk(2, 2, 6, 0, 41), 1'b0, a);
        step("cc2", 1'b1, mk(3, 3, 7, 0, 42), 1'b1, a);
        chk("cc.count_held", 32'(bus.count), 32'd2);
        chk("cc.issued", 32'(bus.issue), 32'd1);
        idle("cc_tail", 1'b1, 6);

        // Async reset mid-stream: count=3, r10 in flight
        step("ar0", 1'b1, mk(1, 2, 10, 0, 50), 1'b0, a);
        step("ar1", 1'b1, mk(10, 2, 11, 0, 51), 1'b0, a);
        step("ar2", 1'b1, mk(10, 10, 12, 0, 52), 1'b0, a);
        step("ar3", 1'b1, mk(4, 4, 13, 0, 53), 1'b1, a);
        chk("ar.pre_count", 32'(bus.count), 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("ar.during");
        #1;
        rst_n = 1'b1;
        step("ar_push", 1'b1, mk(10, 10, 3, 0, 60), 1'b1, a);
        step("ar_issue", 1'b0, BUB, 1'b1, a);
        chk("ar.r10_issue", 32'(bus.issue), 32'd1);
        chk("ar.r10_addr", 32'(bus.addr), 32'd60);

        // Randomized stream over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 99) < 60), mk($urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 254)),
                 ($urandom_range(0, 99) < 80), a);
        end
        idle("rand_tail", 1'b1, 12);
        chk("rand.empty", 32'(bus.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_issue.md
Name: pipe_issue

Overview:
- Instruction issue unit that feeds the 4-stage register/ALU/writeback/memory pipeline.
- Buffers incoming instructions (rs1, rs2, rd, func, addr) in a small FIFO.
- Detects read-after-write hazards against recently issued destinations and inserts harmless bubbles until the operands are written back.
- Drives the pipeline's instruction fields once per clock.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- HAZ_STAGES, 2, number of most recent issue slots whose rd is not yet readable from the register bank.
- BUB_ADDR, 255, memory address driven during bubbles; this location is reserved as scratch.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers an instruction.
- in_ready  output  1  FIFO can accept; equals !full.
- in_rs1  input  4  source register 1.
- in_rs2  input  4  source register 2.
- in_rd  input  4  destination register.
- in_func  input  4  ALU function code.
- in_addr  input  8  result memory address.
- run  input  1  1 = issue permitted; 0 = drive bubbles only.
- rs1, rs2, rd, func  output  4 each  registered instruction fields to the pipeline.
- addr  output  8  registered memory address.
- issue  output  1  1 = current outputs carry a real instruction; 0 = bubble.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- stall_cnt  output  16  hazard stall cycle counter.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, count=0, scoreboard cleared. Outputs become a bubble immediately: rs1=rs2=rd=0, func=3, addr=BUB_ADDR, issue=0. stall_cnt=0. Contents in flight are discarded.
- Bubble encoding: func=3 (pass A), rs1=rs2=rd=0. Register 0 is reserved, so writing it back is idempotent. Bubbles never enter the scoreboard as valid.
- Push: occurs when in_valid && in_ready at a rising edge; data written at the write pointer. in_ready is computed from the count at the start of the cycle. A pop in the same cycle does not free a slot for a push.
- Scoreboard: a HAZ_STAGES-deep shift register of {valid, rd}, shifted every clock. The new entry is {issue_now, rd_issued}.
- Hazard: FIFO head rs1 or rs2 equals any valid scoreboard rd. Both sources are always compared, independent of func.
- Issue decision each edge:
  - If run=1, count>0 and no hazard: pop head, register its fields, issue=1.
  - Otherwise: register a bubble, issue=0.
- No bypass: an entry pushed at edge t is issuable at edge t+1 at the earliest.
- With HAZ_STAGES=2, a dependent instruction issues exactly 3 edges after its producer, i.e. 2 bubbles.
- Pointer wrap: pointers are modulo DEPTH. Full when count=DEPTH; empty when count=0.
- Simultaneous push and pop when not full: count unchanged; order preserved (strict FIFO, no reordering past a stalled head).
- stall_cnt: increments by 1 on each edge where run=1, count>0 and a hazard exists. Saturates at 16'hFFFF. Not incremented while run=0 or while the FIFO is empty.

Optional Feature:
- Macro: PIPE_ISSUE_STALLCNT_EN.
- Defined: stall_cnt operates as specified.
- Undefined: counter logic is omitted and stall_cnt is driven constant 0. The port is still present.

Test Plan:
- Independent stream: push {3,5,10,0,125} then {3,8,12,2,126} back-to-back, run=1 → issue=1 on two consecutive edges; outputs match in order; stall_cnt=0.
- RAW: push {3,5,10,0,125} then {10,5,14,1,128} → second issues 3 edges after first. The two intervening cycles show issue=0, func=3, rd=0, addr=255. stall_cnt=2.
- Full/ordering: run=0, offer 5 instructions with DEPTH=4 → 4 accepted; in_ready=0 at count=4; 5th held on inputs. Set run=1 → issue order is 1,2,3,4,5, and count returns to 0.
- Concurrent push/pop: at count=2 with no hazards, push while issuing → count stays 2 for that edge.
- Async reset mid-stream: drop rst_n between edges with count=3 and scoreboard holding rd=10 → issue=0, bubble outputs and count=0 before the next edge. After release, an instruction reading r10 issues one edge after push with no stall.
- Macro off: repeat the RAW scenario → identical issue timing; stall_cnt reads 0 throughout.
